// File: rtl/instr_align.sv
// Instruction aligner: buffers fetched halfwords in a 4-entry circular queue and
// hands decode one whole instruction per cycle, either 16-bit compressed or 32-bit.
module instr_align #(
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic [31:0] fetch_word,
   output logic        fetch_stall,
   input  logic        flush,
   input  logic        id_stall,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_is_c
);

   logic [15:0] queue_mem [QDEPTH];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [2:0]  count;
   logic [31:0] head_pc;

   logic [15:0] head_lo;
   logic [15:0] head_hi;
   logic        head_is_c;
   logic        head_complete;
   logic        advance;
   logic        load_out;
   logic        accept;
   logic [1:0]  enq_n;
   logic [1:0]  deq_n;
   logic [2:0]  count_after_deq;
   logic        unused_pc_bit;

   assign unused_pc_bit = fetch_pc[0];

   // Stall with three or more halfwords buffered, so a full word always fits.
   assign fetch_stall = (count >= 3'd3);

   always_comb begin
      head_lo         = queue_mem[rd_ptr];
      head_hi         = queue_mem[rd_ptr + 2'd1];
      head_is_c       = (head_lo[1:0] != 2'b11);
      head_complete   = (count >= 3'd1) && (head_is_c || (count >= 3'd2));
      advance         = !id_valid || !id_stall;
      load_out        = advance && head_complete;
      accept          = fetch_valid && !fetch_stall && !flush;
      deq_n           = load_out ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;
      enq_n           = accept ? (fetch_pc[1] ? 2'd1 : 2'd2) : 2'd0;
      count_after_deq = count - {1'b0, deq_n};
   end

   // A word fetched at an odd halfword address only contributes its upper half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QDEPTH; i++) begin
            queue_mem[i] <= '0;
         end
      end else if (accept) begin
         if (fetch_pc[1]) begin
            queue_mem[wr_ptr] <= fetch_word[31:16];
         end else begin
            queue_mem[wr_ptr]        <= fetch_word[15:0];
            queue_mem[wr_ptr + 2'd1] <= fetch_word[31:16];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         head_pc <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + deq_n;
         wr_ptr <= wr_ptr + enq_n;
         count  <= count_after_deq + {1'b0, enq_n};
         // The head address is reloaded whenever new data lands in a queue that drains empty.
         if (accept && (count_after_deq == 3'd0)) begin
            head_pc <= {fetch_pc[31:1], 1'b0};
         end else if (load_out) begin
            head_pc <= head_pc + (head_is_c ? 32'd2 : 32'd4);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         id_is_c  <= 1'b0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (advance) begin
         if (head_complete) begin
            id_valid <= 1'b1;
            id_instr <= head_is_c ? {16'h0000, head_lo} : {head_hi, head_lo};
            id_pc    <= head_pc;
            id_is_c  <= head_is_c;
         end else begin
            id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/instr_align.md
INSTR_ALIGN -- requirements
Module: instr_align

Interface
REQ-001 The block SHALL have the parameter QDEPTH, default 4, giving the halfword queue depth; only 4 is supported.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 The block SHALL have the port fetch_valid, input, 1 bit: fetch_word/fetch_pc are valid this cycle.
REQ-005 The block SHALL have the port fetch_pc, input, 32 bits: fetch address; bit0 is ignored; bit1=1 means start at the upper halfword.
REQ-006 The block SHALL have the port fetch_word, input, 32 bits: the little-endian word at {fetch_pc[31:2],2'b00}.
REQ-007 The block SHALL have the port fetch_stall, output, 1 bit: backpressure to fetch; a word is accepted only when fetch_valid=1 and fetch_stall=0.
REQ-008 The block SHALL have the port flush, input, 1 bit: redirect or jump; it discards all buffered and output state.
REQ-009 The block SHALL have the port id_stall, input, 1 bit: decode cannot take a new instruction.
REQ-010 The block SHALL have the port id_valid, output, 1 bit: id_instr/id_pc hold a valid instruction.
REQ-011 The block SHALL have the port id_instr, output, 32 bits: the raw instruction; a compressed instruction is zero-extended in [15:0].
REQ-012 The block SHALL have the port id_pc, output, 32 bits: the byte address of id_instr.
REQ-013 The block SHALL have the port id_is_c, output, 1 bit: 1 when id_instr is a 16-bit compressed instruction.

Function
REQ-014 The block SHALL hold a circular queue of 4 halfwords with a 2-bit read pointer and a 2-bit write pointer, both wrapping mod 4, and a 3-bit count (0..4).
REQ-015 The block SHALL drive fetch_stall = (count >= 3), combinationally from registered count only.
REQ-016 On an accepted word with fetch_pc[1]=0, the block SHALL enqueue fetch_word[15:0] then fetch_word[31:16] (+2 count).
REQ-017 On an accepted word with fetch_pc[1]=1, the block SHALL enqueue only fetch_word[31:16] (+1 count).
REQ-018 The block SHALL maintain head_pc as the address of the queue head; an enqueue into an empty queue (after the same-cycle dequeue) loads head_pc = {fetch_pc[31:1],1'b0}.
REQ-019 The head halfword SHALL be classified as compressed when head[1:0] != 2'b11, and as 32-bit otherwise.
REQ-020 The head SHALL be complete when it is compressed and count>=1, or when it is 32-bit and count>=2.
REQ-021 The output register SHALL be able to load ("advance") when id_valid=0 or id_stall=0.
REQ-022 On advance with a complete head, the block SHALL register: id_instr = compressed ? {16'h0,head} : {head+1,head}; id_pc = head_pc; id_is_c; id_valid=1; dequeue 1 or 2 halfwords; head_pc += 2 or 4.
REQ-023 On advance with an incomplete head, the block SHALL clear id_valid; id_instr, id_pc and id_is_c keep their values.
REQ-024 While id_valid=1 and id_stall=1, all id_* outputs SHALL be held unchanged and no dequeue SHALL occur.
REQ-025 Latency SHALL be one cycle: an instruction completed by an enqueue at edge N is presented at edge N+1 at the earliest.
REQ-026 Enqueue and dequeue in the same cycle SHALL both take effect; count_next = count + enq - deq, and it never exceeds 4 or falls below 0.
REQ-027 The 32-bit halfword pair SHALL be read across pointer wrap (read pointer 3, then 0).
REQ-028 flush=1 SHALL zero the pointers, count and id_valid at the next edge; fetch input in the flush cycle SHALL be ignored; flush overrides id_stall.
REQ-029 A 32-bit instruction whose upper half has not yet arrived SHALL remain in the queue, with no partial output.

Reset
REQ-030 On reset=0, the block SHALL asynchronously clear pointers, count, head_pc, id_valid, id_instr, id_pc and id_is_c to 0; fetch_stall then reads 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued halfwords; the first accepted word after release SHALL be treated as entering an empty queue.

Verification
REQ-032 The bench SHALL cover: words 0x00000013@0x0, 0x00100093@0x4 with id_stall=0 -> id_valid at pc 0x0 then 0x4, id_is_c=0, one per cycle.
REQ-033 The bench SHALL cover: word 0x45014501@0x8 -> two outputs of 0x00004501 at pc 0x8 and 0xA, id_is_c=1.
REQ-034 The bench SHALL cover: straddle with word 0x00934501@0x10, then 0x00000010@0x14 -> C 0x4501@0x10, then 32-bit 0x00100093@0x12.
REQ-035 The bench SHALL cover: jump to 0x22 with flush=1, then word 0x45010000@0x20 -> only 0x00004501@0x22 is output; pre-flush data never appears.
REQ-036 The bench SHALL cover: id_stall held 5 cycles with continuous fetch -> count saturates at 4, fetch_stall=1, outputs stable, no halfword lost after release.
REQ-037 The bench SHALL cover: reset=0 pulsed while count=3 -> all outputs 0 immediately; the next word@0x40 is output at pc 0x40.
